// File: rtl/bit_deser_pkg.sv
// Shared types and constants for the bit deserializer receive path.
// Optional parity framing is enabled by defining PARITY_EN.
package bit_deser_pkg;

  typedef enum logic {
    ST_SHIFT = 1'b0,
    ST_PAR   = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/bit_deser_rx_if.sv
// Word-side valid/ready handshake of the bit deserializer.
// The perr field exists only when PARITY_EN is defined.
interface bit_deser_rx_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] word_out;
  logic             word_vld;
  logic             word_rdy;
`ifdef PARITY_EN
  logic             perr;
`endif

  modport master (
    input  word_rdy,
`ifdef PARITY_EN
    output perr,
`endif
    output word_out,
    output word_vld
  );

  modport slave (
    output word_rdy,
`ifdef PARITY_EN
    input  perr,
`endif
    input  word_out,
    input  word_vld
  );
endinterface

// File: rtl/bit_deser_rx_fifo.sv
// Synchronous FIFO for assembled words; registered head, no fall-through.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module deser_fifo
  import bit_deser_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        push,
  input  logic [DW-1:0]               din,
  input  logic                        pop,
  output logic [DW-1:0]               dout,
  output logic                        empty,
  output logic [clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_pop, do_push;

  always_comb begin
    empty   = (count == '0);
    full    = (count == CW'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dout    = mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/bit_deser_rx.sv
// Serial-to-word receiver: shifts bits in, queues completed words, hands out over valid/ready.
// Define PARITY_EN to append an even-parity bit per word and report perr per entry.
module bit_deser_rx
  import bit_deser_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int MSB_FIRST = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr,
  input  logic                        bit_in,
  input  logic                        bit_vld,
  bit_deser_rx_if.master              wif,
  output logic [clog2(WIDTH+1)-1:0]   bit_cnt,
  output logic                        overflow
);
  localparam int CW  = clog2(WIDTH + 1);
  localparam int FCW = clog2(DEPTH + 1);
`ifdef PARITY_EN
  localparam int DW  = WIDTH + 1;
`else
  localparam int DW  = WIDTH;
`endif

  state_t           state, state_nx;
  logic [WIDTH-1:0] sr, sr_nx, sr_shift;
  logic [CW-1:0]    cnt_nx;
  logic             push, pop, fifo_empty;
  logic [DW-1:0]    push_din, fifo_dout;
  logic [FCW-1:0]   fifo_cnt;

  always_comb begin
    if (MSB_FIRST != 0) sr_shift = {sr[WIDTH-2:0], bit_in};
    else                sr_shift = {bit_in, sr[WIDTH-1:1]};
  end

  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    cnt_nx   = bit_cnt;
    push     = 1'b0;
    push_din = '0;
    case (state)
      ST_SHIFT: begin
        if (bit_vld) begin
          sr_nx = sr_shift;
          if (bit_cnt == CW'(WIDTH - 1)) begin
            cnt_nx = '0;
`ifdef PARITY_EN
            state_nx = ST_PAR;
`else
            push     = 1'b1;
            push_din = sr_shift;
`endif
          end else begin
            cnt_nx = bit_cnt + CW'(1);
          end
        end
      end
`ifdef PARITY_EN
      ST_PAR: begin
        // completed word waits in sr; the parity bit itself is never shifted in
        if (bit_vld) begin
          push     = 1'b1;
          push_din = {sr, ^{sr, bit_in}};
          state_nx = ST_SHIFT;
        end
      end
`endif
      default: state_nx = ST_SHIFT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_SHIFT;
      sr       <= '0;
      bit_cnt  <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      state    <= ST_SHIFT;
      sr       <= '0;
      bit_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      state   <= state_nx;
      sr      <= sr_nx;
      bit_cnt <= cnt_nx;
      if (push && (fifo_cnt == FCW'(DEPTH)) && !pop) overflow <= 1'b1;
    end
  end

  assign pop = wif.word_vld && wif.word_rdy;

  deser_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push),
    .din   (push_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  assign wif.word_vld = !fifo_empty;
  assign wif.word_out = fifo_dout[DW-1 -: WIDTH];
`ifdef PARITY_EN
  assign wif.perr     = fifo_dout[0];
`endif
endmodule
